// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types and helpers for param_regfile_dump
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

  localparam int PARITY_MAX_W = 256;

  // Even-parity bit: XOR of all data bits, so data plus this bit has even weight.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] value);
    return ^value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_dump_seq.sv
// ============================================================================
// regfile_dump_seq : dump FSM walking every register index over valid/ready
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ena && dump_start) begin
          state_d = ST_EMIT;
          addr_d  = '0;
        end
      end
      ST_EMIT: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (ena && dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        // Leaves unconditionally so the done pulse is exactly one cycle wide.
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/param_regfile_dump.sv
// ============================================================================
// param_regfile_dump : parametrised register file, bypassed read ports, dump
//                      streamer; optional parity under REGFILE_PARITY_EN
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module param_regfile_dump
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  parameter  int NUM_RD   = 2,
  parameter  int R0_ZERO  = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     dump_start,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done,
`ifdef REGFILE_PARITY_EN
  input  logic                     par_inject,
`endif
  output logic                     par_err
);

  localparam int              NUM_PORTS    = NUM_RD + 1;
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = ena && wr_en && ({1'b0, wr_addr} < NUM_REGS_EXT)
                 && !((R0_ZERO != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_dump_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

`ifdef REGFILE_PARITY_EN
  logic                 par_q [NUM_REGS];
  logic                 par_err_q;
  logic [NUM_PORTS-1:0] par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) par_q[i] <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (wr_ok) par_q[wr_addr] <= even_parity(PARITY_MAX_W'(wr_data)) ^ par_inject;
      if (|par_bad) par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // Port index NUM_RD is the dump path; it shares the read/bypass logic.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              in_rng;
    logic              forced0;
    logic              byp;

    if (k < NUM_RD) begin : g_rd
      assign addr                        = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = val;
    end else begin : g_dump
      assign addr      = dump_addr;
      assign dump_data = val;
    end

    assign in_rng  = ({1'b0, addr} < NUM_REGS_EXT);
    assign forced0 = (R0_ZERO != 0) && (addr == '0);
    assign byp     = wr_ok && (wr_addr == addr);
    assign val     = (!in_rng || forced0) ? '0 : (byp ? wr_data : mem_q[addr]);

`ifdef REGFILE_PARITY_EN
    assign par_bad[k] = ena && ((k < NUM_RD) || dump_valid) && in_rng && !forced0 && !byp
                        && (even_parity(PARITY_MAX_W'(mem_q[addr])) != par_q[addr]);
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_param_regfile_dump.sv
// ============================================================================
// tb_param_regfile_dump : randomized self-checking bench for param_regfile_dump
// Rev 1.0               : initial release
// ============================================================================
`default_nettype none

module tb_param_regfile_dump;

  localparam int DW  = 8;
  localparam int NR  = 8;
  localparam int NRD = 2;
  localparam int AW  = 3;

  logic           clk = 1'b0;
  logic           rst_n, ena, wr_en, dump_start, dump_ready, par_inject;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [NRD*AW-1:0] rd_addr;

  logic [NRD*DW-1:0] rd_data,    rd_data_z;
  logic              dump_valid, dump_valid_z, dump_busy, dump_busy_z;
  logic              dump_done,  dump_done_z,  par_err,   par_err_z;
  logic [AW-1:0]     dump_addr,  dump_addr_z;
  logic [DW-1:0]     dump_data,  dump_data_z;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_mem  [NR];
  logic [DW-1:0] m_memz [NR];

  always #5 clk = ~clk;

  param_regfile_dump #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .R0_ZERO(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done),
`ifdef REGFILE_PARITY_EN
    .par_inject(par_inject),
`endif
    .par_err(par_err)
  );

  param_regfile_dump #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .R0_ZERO(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .dump_start(dump_start), .dump_valid(dump_valid_z), .dump_ready(dump_ready),
    .dump_addr(dump_addr_z), .dump_data(dump_data_z), .dump_busy(dump_busy_z),
    .dump_done(dump_done_z),
`ifdef REGFILE_PARITY_EN
    .par_inject(par_inject),
`endif
    .par_err(par_err_z)
  );

  // Reference read: range check, hard-wired zero, then write-through bypass.
  function automatic logic [DW-1:0] m_read(input int a, input bit r0z);
    if (a >= NR) return '0;
    if (r0z && a == 0) return '0;
    if (ena && wr_en && int'(wr_addr) == a) return wr_data;
    return r0z ? m_memz[a] : m_mem[a];
  endfunction

  task automatic tick();
    if (ena && wr_en) begin
      m_mem[wr_addr] = wr_data;
      if (wr_addr != 0) m_memz[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; dump_start = 1'b0; dump_ready = 1'b0; par_inject = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_memz[i] = '0; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NR; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      for (int k = 0; k < NRD; k++) begin
        tests_run++;
        if (rd_data[k*DW +: DW] !== '0 || rd_data_z[k*DW +: DW] !== '0) begin
          tests_failed++;
          $display("FAIL %s addr=%0d port=%0d got %h/%h exp 00", tag, a, k,
                   rd_data[k*DW +: DW], rd_data_z[k*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dump_valid, dump_busy, dump_done, par_err, dump_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b pe=%b a=%0d exp all 0",
               dump_valid, dump_busy, dump_done, par_err, dump_addr);
    end
    apply_reset();
    check_all_zero("reset_read");
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr = {3'd3, 3'd3};
    #1;
    for (int k = 0; k < NRD; k++) begin
      tests_run++;
      if (rd_data[k*DW +: DW] !== 8'hA5) begin
        tests_failed++;
        $display("FAIL bypass_same_cycle port=%0d got %h exp a5", k, rd_data[k*DW +: DW]);
      end
    end
    tick();
    wr_en = 1'b0;
    #1;
    for (int k = 0; k < NRD; k++) begin
      tests_run++;
      if (rd_data[k*DW +: DW] !== 8'hA5) begin
        tests_failed++;
        $display("FAIL bypass_next_cycle port=%0d got %h exp a5", k, rd_data[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_r0();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rd_addr = {3'd0, 3'd0};
    #1;
    tests_run++;
    if (rd_data[DW-1:0] !== 8'hFF || rd_data_z[DW-1:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL r0_bypass got %h/%h exp ff/00", rd_data[DW-1:0], rd_data_z[DW-1:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    tests_run++;
    if (rd_data[DW-1:0] !== 8'hFF || rd_data_z[DW-1:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL r0_stored got %h/%h exp ff/00", rd_data[DW-1:0], rd_data_z[DW-1:0]);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int it = 0; it < 80; it++) begin
      ena     = ($urandom_range(0, 3) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      rd_addr = (NRD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      #1;
      for (int k = 0; k < NRD; k++) begin
        tests_run++;
        if (rd_data[k*DW +: DW] !== m_read(int'(rd_addr[k*AW +: AW]), 1'b0) ||
            rd_data_z[k*DW +: DW] !== m_read(int'(rd_addr[k*AW +: AW]), 1'b1)) begin
          tests_failed++;
          $display("FAIL random_read it=%0d port=%0d addr=%0d got %h/%h exp %h/%h",
                   it, k, rd_addr[k*AW +: AW], rd_data[k*DW +: DW], rd_data_z[k*DW +: DW],
                   m_read(int'(rd_addr[k*AW +: AW]), 1'b0), m_read(int'(rd_addr[k*AW +: AW]), 1'b1));
        end
      end
      tick();
    end
    tests_run++;
    if (par_err !== 1'b0 || par_err_z !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_par_err got %b/%b exp 0/0", par_err, par_err_z);
    end
  endtask

  task automatic test_dump();
    int idx;
    idle_inputs();
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    dump_start = 1'b1;
    #1;
    tests_run++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_idle_before_start got v=%b b=%b exp 0/0", dump_valid, dump_busy);
    end
    tick();
    dump_start = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < NR; cyc++) begin
      dump_ready = (cyc % 2 == 0);
      ena        = (cyc != 6);
      dump_start = (cyc == 3);
      #1;
      tests_run++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0 ||
          int'(dump_addr) !== idx || dump_data !== m_read(idx, 1'b0) ||
          int'(dump_addr_z) !== idx || dump_data_z !== m_read(idx, 1'b1)) begin
        tests_failed++;
        $display("FAIL dump_beat cyc=%0d got v=%b b=%b d=%b a=%0d data=%h/%h exp a=%0d data=%h/%h",
                 cyc, dump_valid, dump_busy, dump_done, dump_addr, dump_data, dump_data_z,
                 idx, m_read(idx, 1'b0), m_read(idx, 1'b1));
      end
      if (ena && dump_ready) idx++;
      tick();
    end
    ena = 1'b1; dump_ready = 1'b0; dump_start = 1'b0;
    #1;
    tests_run++;
    if (idx != NR || dump_done !== 1'b1 || dump_done_z !== 1'b1 ||
        dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL dump_done_pulse beats=%0d got d=%b/%b v=%b b=%b exp 8 beats d=1 v=0 b=1",
               idx, dump_done, dump_done_z, dump_valid, dump_busy);
    end
    tick();
    tests_run++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_back_to_idle got d=%b b=%b v=%b exp 0/0/0", dump_done, dump_busy, dump_valid);
    end
  endtask

  task automatic test_mid_dump_reset();
    idle_inputs();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    dump_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h99;
    #1;
    tests_run++;
    if (dump_addr !== 3'd4 || dump_valid !== 1'b1 || dump_data !== 8'h99 || dump_data_z !== 8'h99) begin
      tests_failed++;
      $display("FAIL dump_write_through got a=%0d v=%b data=%h/%h exp a=4 v=1 data=99/99",
               dump_addr, dump_valid, dump_data, dump_data_z);
    end
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_addr !== '0) begin
      tests_failed++;
      $display("FAIL dump_async_reset got v=%b b=%b d=%b a=%0d exp 0/0/0/0",
               dump_valid, dump_busy, dump_done, dump_addr);
    end
    for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_memz[i] = '0; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      tests_run++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL dump_no_done_after_reset n=%0d got d=%b v=%b exp 0/0", n, dump_done, dump_valid);
      end
    end
    check_all_zero("post_dump_reset_read");
  endtask

  task automatic test_parity();
`ifdef REGFILE_PARITY_EN
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C; par_inject = 1'b1; rd_addr = {3'd2, 3'd2};
    tick();
    wr_en = 1'b0; par_inject = 1'b0;
    tick();
    tests_run++;
    if (par_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_detect got %b exp 1", par_err);
    end
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    tests_run++;
    if (par_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_sticky got %b exp 1", par_err);
    end
    apply_reset();
    tests_run++;
    if (par_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_cleared got %b exp 0", par_err);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_r0();
    test_random();
    test_dump();
    test_mid_dump_reset();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_regfile_dump.md
Name: param_regfile_dump

Overview:
- Parametrised successor to the processor's fixed 8x8 register file.
- Configurable data width, register count and read-port count.
- Write-through bypass on every read port.
- Built-in dump sequencer that streams every register over a valid/ready port, so benches and the top-level debug mux read state without hierarchical peeking.
- Sits inside the processor core and replaces the current rf instance.

Parameters:
- DATA_W, 8: register width in bits.
- NUM_REGS, 8: number of registers (>=2, need not be a power of two).
- NUM_RD, 2: number of combinational read ports.
- R0_ZERO, 0: if 1, register 0 reads as zero and ignores writes.
- ADDR_W, $clog2(NUM_REGS): address width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; when 0, writes and dump advance are frozen
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- dump_start  in  1  request full register dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_addr  out  ADDR_W  index of current beat
- dump_data  out  DATA_W  value of current beat
- dump_busy  out  1  sequencer not idle
- dump_done  out  1  one-cycle pulse after last beat accepted
- par_err  out  1  sticky parity error (REGFILE_PARITY_EN only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): all registers 0; FSM IDLE; dump_valid, dump_busy, dump_done, par_err = 0; dump_addr = 0.
- Write: on rising clk with ena & wr_en & (wr_addr < NUM_REGS) & !(R0_ZERO & wr_addr==0). Out-of-range writes are dropped silently.
- Read: combinational, zero latency. If ena & wr_en & wr_addr==rd_addr and the write is legal, rd_data returns wr_data (bypass). Out-of-range address returns 0. R0_ZERO reads of address 0 return 0.
- Dump FSM states: IDLE, EMIT, DONE.
  - IDLE -> EMIT on ena & dump_start; dump_addr <= 0.
  - EMIT: dump_valid=1. dump_data is the live read of dump_addr, bypass included, so a same-cycle write to that address is reflected.
  - On ena & dump_ready in EMIT: if dump_addr==NUM_REGS-1, go to DONE; else dump_addr++.
  - DONE: dump_done=1 for exactly one cycle, then IDLE. dump_busy=1 in EMIT and DONE.
  - dump_valid/dump_addr/dump_data are held stable while !dump_ready or !ena.
- dump_start while busy is ignored (no restart, no queueing).
- ena low mid-dump: FSM holds state; dump_valid stays asserted.
- rst_n low mid-dump: immediate return to IDLE; outputs per reset; no dump_done pulse.
- Dump and normal read ports are independent; writes continue during a dump.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit computed on write.
  - Every read port and the dump path recompute parity; a mismatch on any enabled read sets par_err, sticky until reset.
  - Bypassed reads are not checked.
  - Adds a hidden test input port par_inject (1 bit): when high, the stored parity of the written entry is inverted.
- Undefined: no parity storage, no par_inject port, par_err tied 0.

Decomposition:
- Package regfile_pkg: dump FSM state enum (IDLE/EMIT/DONE) and a parity function.
- Sub-module regfile_dump_seq: the dump FSM and address counter. It drives a dump read address into the array and registers nothing else.
- The storage array and read/bypass muxing stay in the top module.

Test Plan:
- Reset then read all addresses on both ports -> all 0; dump_busy=0, dump_valid=0.
- Write 0xA5 to r3, read port0=r3 and port1=r3 in the same cycle -> both 0xA5 (bypass); next cycle still 0xA5.
- R0_ZERO=1: write 0xFF to r0 -> read r0 = 0x00. R0_ZERO=0: same write -> r0 = 0xFF.
- Preload r0..r7 = 0x10..0x17; pulse dump_start; dump_ready toggles 1,0,1,... -> beats addr 0..7 with data 0x10..0x17, each held while ready=0; dump_done pulses once 1 cycle after beat 7.
- Mid-dump at addr 4: write 0x99 to r4 in the beat cycle -> that beat shows 0x99. Then assert rst_n=0 -> FSM IDLE, dump_valid=0, no dump_done, all registers 0.
- With REGFILE_PARITY_EN: write r2=0x3C with par_inject=1, then read r2 -> par_err=1 and stays 1 after clean reads until reset.
